// File: rtl/game_pkg.sv
// Pipe geometry, colours, position types and gap/reset helpers for draw_pipes.
package game_pkg;
    import vga_pkg::*;

    localparam int unsigned NUM_PIPES = 3;
    localparam int unsigned PIPE_W    = 96;
    localparam int unsigned EDGE_W    = 4;
    localparam int unsigned GAP_H     = 200;
    localparam int unsigned GAP_MIN   = 64;
    localparam int unsigned SPACING   = 384;
    localparam int unsigned SPEED     = 4;
    localparam int unsigned BIRD_X    = 256;
    localparam int unsigned X_W       = 12;
    localparam int unsigned GAP_W     = 10;

    localparam logic [RGB_W-1:0] PIPE_RGB  = 12'h0A0;
    localparam logic [RGB_W-1:0] EDGE_RGB  = 12'h060;
    localparam logic [15:0]      LFSR_SEED = 16'hACE1;

    typedef logic signed [X_W-1:0] pipe_x_t;
    typedef logic [GAP_W-1:0]      gap_t;

    // Reset/restart left edge of pipe i: staggered off the right edge.
    function automatic pipe_x_t x_rst(input int unsigned i);
        return pipe_x_t'(H_RES + i * SPACING);
    endfunction

    // Reset/restart gap top of pipe i.
    function automatic gap_t gap_rst(input int unsigned i);
        return gap_t'(GAP_MIN + 64 * i);
    endfunction

    // Gap for a respawning pipe: per-pipe rotated LFSR slice folded into 64..447.
    function automatic gap_t new_gap(input logic [15:0] lfsr, input int unsigned i);
        logic [15:0] rot;
        logic [8:0]  r;
        rot = (lfsr << (3 * i)) | (lfsr >> (16 - 3 * i));
        r   = rot[8:0];
        if (r >= 9'd384) begin
            r = r - 9'd256;
        end
        return gap_t'(GAP_MIN) + gap_t'(r);
    endfunction
endpackage

// File: rtl/vga_pkg.sv
// VGA timing constants and bus widths for the 1024x768 pixel pipeline.
package vga_pkg;
    localparam int unsigned H_RES = 1024;
    localparam int unsigned V_RES = 768;
    localparam int unsigned HC_W  = 11;
    localparam int unsigned RGB_W = 12;
endpackage

// File: rtl/vga_if.sv
// VGA pixel stream bundle: timing counters, sync/blank flags and rgb.
interface vga_if;
    import vga_pkg::*;
    logic [HC_W-1:0]  hcount;
    logic [HC_W-1:0]  vcount;
    logic             hsync;
    logic             vsync;
    logic             hblnk;
    logic             vblnk;
    logic [RGB_W-1:0] rgb;

    modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
    modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR, taps x^16+x^14+x^13+x^11, advancing once per step pulse.
// Ports: clk, rst_n (async active-low), step (advance enable), state (current value).
module lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        step,
    output logic [15:0] state
);
    logic [15:0] state_q;
    logic [15:0] state_d;

    always_comb begin
        state_d = state_q;
        if (step) begin
            state_d = {state_q[0] ^ state_q[2] ^ state_q[3] ^ state_q[5], state_q[15:1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SEED;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;
endmodule

// File: rtl/draw_pipes.sv
// Overlays scrolling pipe pairs on the background pixel stream (1-cycle latency).
// Ports: clk, rst_n (async active-low), enable (scroll enable), restart (sync
// position reload), vin (background stream), vout (composited stream),
// pipe_px (vout pixel belongs to a pipe), score_pulse (pipe cleared BIRD_X).
module draw_pipes
    import vga_pkg::*;
    import game_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic restart,
    vga_if.in    vin,
    vga_if.out   vout,
    output logic pipe_px,
    output logic score_pulse
);
    // 13-bit signed workspace so off-screen left edges compare correctly with hcount.
    typedef logic signed [12:0] px_t;

    localparam px_t     PW13      = px_t'(PIPE_W);
    localparam px_t     EW13      = px_t'(EDGE_W);
    localparam pipe_x_t RESPAWN_X = -pipe_x_t'(PIPE_W);
    // Pipe right edge crosses BIRD_X when its left edge crosses BIRD_X-PIPE_W.
    localparam pipe_x_t SCORE_X   = pipe_x_t'(BIRD_X - PIPE_W);

    pipe_x_t x_q   [NUM_PIPES];
    pipe_x_t x_d   [NUM_PIPES];
    pipe_x_t nx    [NUM_PIPES];
    gap_t    gap_q [NUM_PIPES];
    gap_t    gap_d [NUM_PIPES];
    px_t     xl    [NUM_PIPES];
    px_t     hc;

    logic             prev_vblnk_q;
    logic             frame_evt;
    logic [15:0]      lfsr;
    logic             score_q, score_d;
    logic [NUM_PIPES-1:0] hit, lip;

    logic [HC_W-1:0]  hcount_q, vcount_q;
    logic             hsync_q, vsync_q, hblnk_q, vblnk_q;
    logic [RGB_W-1:0] rgb_q, rgb_d;
    logic             pipe_px_q, pipe_px_d;

    assign frame_evt = vin.vblnk && !prev_vblnk_q;

    lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .step  (frame_evt),
        .state (lfsr)
    );

    // Per-frame scroll, respawn and score detection; restart overrides the frame.
    always_comb begin
        score_d = 1'b0;
        for (int unsigned i = 0; i < NUM_PIPES; i++) begin
            nx[i]    = x_q[i] - pipe_x_t'(SPEED);
            x_d[i]   = x_q[i];
            gap_d[i] = gap_q[i];
            if (restart) begin
                x_d[i]   = x_rst(i);
                gap_d[i] = gap_rst(i);
            end else if (frame_evt && enable) begin
                if (nx[i] <= RESPAWN_X) begin
                    x_d[i]   = nx[i] + pipe_x_t'(NUM_PIPES * SPACING);
                    gap_d[i] = new_gap(lfsr, i);
                end else begin
                    x_d[i] = nx[i];
                end
                if ((x_q[i] > SCORE_X) && (nx[i] <= SCORE_X)) begin
                    score_d = 1'b1;
                end
            end
        end
    end

    // Pixel hit/lip test against the current frame's geometry.
    always_comb begin
        hc = px_t'({2'b00, vin.hcount});
        for (int unsigned i = 0; i < NUM_PIPES; i++) begin
            xl[i]  = px_t'(x_q[i]);
            hit[i] = (hc >= xl[i]) && (hc < xl[i] + PW13) &&
                     ((vin.vcount < HC_W'(gap_q[i])) ||
                      (vin.vcount >= HC_W'(gap_q[i]) + HC_W'(GAP_H)));
            lip[i] = hit[i] && ((hc < xl[i] + EW13) || (hc >= xl[i] + PW13 - EW13));
        end
        rgb_d     = vin.rgb;
        pipe_px_d = 1'b0;
        if (!(vin.hblnk || vin.vblnk)) begin
            pipe_px_d = |hit;
            if (|lip) begin
                rgb_d = EDGE_RGB;
            end else if (|hit) begin
                rgb_d = PIPE_RGB;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_PIPES; i++) begin
                x_q[i]   <= x_rst(i);
                gap_q[i] <= gap_rst(i);
            end
            prev_vblnk_q <= 1'b0;
            score_q      <= 1'b0;
            hcount_q     <= '0;
            vcount_q     <= '0;
            hsync_q      <= 1'b0;
            vsync_q      <= 1'b0;
            hblnk_q      <= 1'b0;
            vblnk_q      <= 1'b0;
            rgb_q        <= '0;
            pipe_px_q    <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < NUM_PIPES; i++) begin
                x_q[i]   <= x_d[i];
                gap_q[i] <= gap_d[i];
            end
            prev_vblnk_q <= vin.vblnk;
            score_q      <= score_d;
            hcount_q     <= vin.hcount;
            vcount_q     <= vin.vcount;
            hsync_q      <= vin.hsync;
            vsync_q      <= vin.vsync;
            hblnk_q      <= vin.hblnk;
            vblnk_q      <= vin.vblnk;
            rgb_q        <= rgb_d;
            pipe_px_q    <= pipe_px_d;
        end
    end

    assign vout.hcount = hcount_q;
    assign vout.vcount = vcount_q;
    assign vout.hsync  = hsync_q;
    assign vout.vsync  = vsync_q;
    assign vout.hblnk  = hblnk_q;
    assign vout.vblnk  = vblnk_q;
    assign vout.rgb    = rgb_q;
    assign pipe_px     = pipe_px_q;
    assign score_pulse = score_q;
endmodule

// File: tb/tb_draw_pipes.sv
// Randomized scoreboard bench for draw_pipes against a frame-level game model.
module tb_draw_pipes;
    localparam int NP      = 3;
    localparam int PW      = 96;
    localparam int EW      = 4;
    localparam int GH      = 200;
    localparam int SP      = 384;
    localparam int STEP    = 4;
    localparam int BIRD    = 256;
    localparam logic [11:0] C_PIPE = 12'h0A0;
    localparam logic [11:0] C_EDGE = 12'h060;

    typedef struct {
        int          cyc;
        logic [10:0] h;
        logic [10:0] v;
        logic        hs;
        logic        vs;
        logic        hb;
        logic        vb;
        logic [11:0] rgb;
        logic        px;
        logic        sc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic en;
    logic rs;
    logic pipe_px;
    logic score_pulse;

    vga_if vin_if ();
    vga_if vout_if ();

    draw_pipes dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (en),
        .restart     (rs),
        .vin         (vin_if),
        .vout        (vout_if),
        .pipe_px     (pipe_px),
        .score_pulse (score_pulse)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp  = 0;
    int n_fail = 0;
    exp_t sb[$];

    // Game model state.
    int          m_x [NP];
    int          m_g [NP];
    int unsigned m_lfsr;
    bit          m_prev;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic void model_positions_reset();
        for (int i = 0; i < NP; i++) begin
            m_x[i] = 1024 + i * SP;
            m_g[i] = 64 + 64 * i;
        end
    endfunction

    function automatic int unsigned lfsr_next(input int unsigned s);
        int unsigned fb;
        fb = $countones(s & 32'h002D) % 2;
        return (s >> 1) | (fb << 15);
    endfunction

    function automatic int model_gap(input int unsigned s, input int i);
        int unsigned rot;
        int r;
        rot = ((s << (3 * i)) | (s >> (16 - 3 * i))) & 32'hFFFF;
        r = int'(rot % 512);
        if (r >= 384) r = r - 256;
        return 64 + r;
    endfunction

    function automatic void model_pixel(input int h, input int v, input logic hb, input logic vb,
                                        input logic [11:0] rgb_in,
                                        output logic [11:0] rgb, output logic px);
        bit hit_any;
        bit lip_any;
        hit_any = 0;
        lip_any = 0;
        for (int i = 0; i < NP; i++) begin
            if (h >= m_x[i] && h < m_x[i] + PW && (v < m_g[i] || v >= m_g[i] + GH)) begin
                hit_any = 1;
                if (h < m_x[i] + EW || h >= m_x[i] + PW - EW) lip_any = 1;
            end
        end
        if (hb || vb) begin
            rgb = rgb_in;
            px  = 1'b0;
        end else begin
            rgb = lip_any ? C_EDGE : (hit_any ? C_PIPE : rgb_in);
            px  = hit_any;
        end
    endfunction

    task automatic model_step(input logic vb, input logic e_en, input logic e_rs, output logic sc);
        bit fe;
        int nxt;
        fe = vb && !m_prev;
        sc = 1'b0;
        if (e_rs) begin
            model_positions_reset();
        end else if (fe && e_en) begin
            for (int i = 0; i < NP; i++) begin
                nxt = m_x[i] - STEP;
                if (m_x[i] + PW > BIRD && nxt + PW <= BIRD) sc = 1'b1;
                if (nxt <= -PW) begin
                    m_x[i] = nxt + NP * SP;
                    m_g[i] = model_gap(m_lfsr, i);
                end else begin
                    m_x[i] = nxt;
                end
            end
        end
        if (fe) m_lfsr = lfsr_next(m_lfsr);
        m_prev = vb;
    endtask

    task automatic drive(input int h, input int v, input logic hb, input logic vb,
                         input logic e_en, input logic e_rs);
        exp_t e;
        logic [11:0] rgb;
        @(posedge clk);
        #1;
        rgb = 12'($urandom);
        vin_if.hcount = 11'(h);
        vin_if.vcount = 11'(v);
        vin_if.hsync  = 1'($urandom);
        vin_if.vsync  = 1'($urandom);
        vin_if.hblnk  = hb;
        vin_if.vblnk  = vb;
        vin_if.rgb    = rgb;
        en = e_en;
        rs = e_rs;
        e.cyc = cyc;
        e.h   = 11'(h);
        e.v   = 11'(v);
        e.hs  = vin_if.hsync;
        e.vs  = vin_if.vsync;
        e.hb  = hb;
        e.vb  = vb;
        model_pixel(h, v, hb, vb, rgb, e.rgb, e.px);
        model_step(vb, e_en, e_rs, e.sc);
        sb.push_back(e);
    endtask

    // Pixel picker biased toward pipe columns and gap edges.
    task automatic pick(output int h, output int v);
        int j;
        j = int'($urandom_range(0, NP - 1));
        h = m_x[j] + int'($urandom_range(0, PW + 3)) - 2;
        if (h < 0 || h > 1343) h = int'($urandom_range(0, 1023));
        if ($urandom_range(0, 1) == 1) v = m_g[j] + int'($urandom_range(0, GH + 20)) - 10;
        else v = int'($urandom_range(0, 767));
        if (v < 0 || v > 767) v = int'($urandom_range(0, 767));
    endtask

    task automatic run_frame(input int f);
        logic e_en;
        int h;
        int v;
        e_en = !(f >= 300 && f < 305) && ($urandom_range(0, 15) != 0);
        for (int k = 0; k < 6; k++) begin
            pick(h, v);
            drive(h, v, 1'b0, 1'b0, e_en, (f == 450 && k == 2));
        end
        pick(h, v);
        drive(h, v, 1'b1, 1'b0, e_en, 1'b0);
        pick(h, v);
        drive(h, v, 1'b0, 1'b1, e_en, (f == 520));
        pick(h, v);
        drive(h, v, 1'b1, 1'b1, e_en, 1'b0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_hcount"}, 64'(vout_if.hcount), 64'd0);
        check({tag, "_vcount"}, 64'(vout_if.vcount), 64'd0);
        check({tag, "_sync"},   64'({vout_if.hsync, vout_if.vsync}), 64'd0);
        check({tag, "_blnk"},   64'({vout_if.hblnk, vout_if.vblnk}), 64'd0);
        check({tag, "_rgb"},    64'(vout_if.rgb), 64'd0);
        check({tag, "_pipe_px"}, 64'(pipe_px), 64'd0);
        check({tag, "_score"},  64'(score_pulse), 64'd0);
    endtask

    task automatic drain();
        for (int k = 0; k < 10 && sb.size() > 0; k++) begin
            @(negedge clk);
            #1;
        end
        if (sb.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain: %0d expected outputs never presented, required 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic model_reset_all();
        model_positions_reset();
        m_lfsr = 32'hACE1;
        m_prev = 1'b0;
    endtask

    // Monitor: one output per cycle, compared against the oldest matured expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && sb.size() > 0 && sb[0].cyc < cyc) begin
            e = sb.pop_front();
            check("timing", 64'({vout_if.hcount, vout_if.vcount, vout_if.hsync, vout_if.vsync,
                                 vout_if.hblnk, vout_if.vblnk}),
                            64'({e.h, e.v, e.hs, e.vs, e.hb, e.vb}));
            check("rgb", 64'(vout_if.rgb), 64'(e.rgb));
            check("pipe_px", 64'(pipe_px), 64'(e.px));
            check("score_pulse", 64'(score_pulse), 64'(e.sc));
        end
    end

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        rs    = 1'b0;
        vin_if.hcount = 11'd300;
        vin_if.vcount = 11'd100;
        vin_if.hsync  = 1'b1;
        vin_if.vsync  = 1'b1;
        vin_if.hblnk  = 1'b0;
        vin_if.vblnk  = 1'b0;
        vin_if.rgb    = 12'hFFF;
        model_reset_all();
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        for (int f = 0; f < 560; f++) run_frame(f);
        drain();

        // Asynchronous reset in the middle of a line.
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_zero("midreset");
        sb.delete();
        model_reset_all();
        vin_if.vblnk = 1'b0;
        en = 1'b0;
        rs = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int f = 0; f < 30; f++) run_frame(1000 + f);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
